// File: rtl/bist_pkg.sv
// Shared BIST definitions: checker state encoding, MISR defaults and the
// expected applied-cycle count derived from the controller's N/M loop bounds.
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPACT = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } bist_state_e;

  localparam int BIST_N = 8;
  localparam int BIST_M = 9;

  // Controller runs (N+1)*(M+1) slots but the final one carries BIST_END only.
  function automatic int exp_cycles(input int n, input int m);
    return (n + 1) * (m + 1) - 1;
  endfunction

  localparam int         EXP_CYCLES_DEF = exp_cycles(BIST_N, BIST_M);
  localparam logic [7:0] POLY_DEF       = 8'h1D;
  localparam logic [7:0] SEED_DEF       = 8'hFF;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register; load has priority over en, one-edge update.
module bist_misr
  import bist_pkg::*;
#(
  parameter int         W    = 8,
  parameter logic [W-1:0] POLY = W'(POLY_DEF),
  parameter logic [W-1:0] SEED = W'(SEED_DEF)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] sig
);

  logic [W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = SEED;
    end else if (en) begin
      sig_d = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/bist_checker.sv
// BIST response checker: compacts responses while RUNNING, then judges signature,
// cycle count and clean end; verdict two edges after RUNNING falls, held until CLEAR.
module bist_checker
  import bist_pkg::*;
#(
  parameter int           W          = 8,
  parameter int           CW         = 8,
  parameter int           EXP_CYCLES = EXP_CYCLES_DEF,
  parameter logic [W-1:0] POLY       = W'(POLY_DEF),
  parameter logic [W-1:0] SEED       = W'(SEED_DEF),
  parameter logic [W-1:0] GOLDEN     = '0
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         RUNNING,
  input  logic         BIST_END,
  input  logic [W-1:0] DATA_IN,
  input  logic         CLEAR,
  output logic         BUSY,
  output logic         DONE,
  output logic         PASS,
  output logic         FAIL,
  output logic [W-1:0] SIGNATURE
);

  localparam logic [CW-1:0] EXP_CNT = CW'(EXP_CYCLES);

  bist_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          ended_q, ended_d;
  logic          pass_q, pass_d;
  logic          fail_q, fail_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          misr_load, misr_en;
  logic [W-1:0]  sig;

  bist_misr #(
    .W    (W),
    .POLY (POLY),
    .SEED (SEED)
  ) u_misr (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .load    (misr_load),
    .en      (misr_en),
    .data_in (DATA_IN),
    .sig     (sig)
  );

  // Saturate rather than wrap so an overlong run can never alias to EXP_CYCLES.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ended_d   = ended_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    misr_load = 1'b0;
    misr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (RUNNING) begin
          misr_en = 1'b1;
          cnt_d   = cnt_inc;
          state_d = ST_COMPACT;
        end
      end
      ST_COMPACT: begin
        if (RUNNING) begin
          misr_en = 1'b1;
          cnt_d   = cnt_inc;
        end else begin
          ended_d = BIST_END;
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        pass_d  = ended_q && (sig == GOLDEN) && (cnt_q == EXP_CNT);
        fail_d  = !(ended_q && (sig == GOLDEN) && (cnt_q == EXP_CNT));
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (CLEAR) begin
          misr_load = 1'b1;
          cnt_d     = '0;
          ended_d   = 1'b0;
          pass_d    = 1'b0;
          fail_d    = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_COMPACT) || (state_d == ST_COMPARE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ended_q <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ended_q <= ended_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PASS      = pass_q;
  assign FAIL      = fail_q;
  assign SIGNATURE = sig;

endmodule

// File: tb/tb_bist_checker.sv
// Bench for bist_checker: four builds sharing one stimulus stream, each tracked by
// a run-level model (signature fold, saturating count, verdict rule).
module tb_bist_checker;

  localparam int NI = 4;

  function automatic logic [7:0] step(input logic [7:0] s, input logic [7:0] d);
    return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ d;
  endfunction

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 37 + 5);
  endfunction

  function automatic logic [7:0] gold_run(input int n);
    logic [7:0] s;
    s = 8'hFF;
    for (int i = 0; i < n; i++) s = step(s, pat(i));
    return s;
  endfunction

  localparam logic [7:0] GOLD89 = gold_run(89);

  logic       CLK = 1'b0;
  logic       RESET_N, RUNNING, BIST_END, CLEAR;
  logic [7:0] DATA_IN;
  logic       busy [NI];
  logic       done [NI];
  logic       pass [NI];
  logic       fail [NI];
  logic [7:0] sig  [NI];

  always #5 CLK = ~CLK;

  bist_checker #(.GOLDEN(GOLD89)) u_main (
    .CLK(CLK), .RESET_N(RESET_N), .RUNNING(RUNNING), .BIST_END(BIST_END),
    .DATA_IN(DATA_IN), .CLEAR(CLEAR), .BUSY(busy[0]), .DONE(done[0]),
    .PASS(pass[0]), .FAIL(fail[0]), .SIGNATURE(sig[0]));

  bist_checker #(.EXP_CYCLES(2), .SEED(8'h01), .GOLDEN(8'h04)) u_small (
    .CLK(CLK), .RESET_N(RESET_N), .RUNNING(RUNNING), .BIST_END(BIST_END),
    .DATA_IN(DATA_IN), .CLEAR(CLEAR), .BUSY(busy[1]), .DONE(done[1]),
    .PASS(pass[1]), .FAIL(fail[1]), .SIGNATURE(sig[1]));

  bist_checker #(.SEED(8'h80)) u_s80 (
    .CLK(CLK), .RESET_N(RESET_N), .RUNNING(RUNNING), .BIST_END(BIST_END),
    .DATA_IN(DATA_IN), .CLEAR(CLEAR), .BUSY(busy[2]), .DONE(done[2]),
    .PASS(pass[2]), .FAIL(fail[2]), .SIGNATURE(sig[2]));

  bist_checker #(.SEED(8'h00)) u_s00 (
    .CLK(CLK), .RESET_N(RESET_N), .RUNNING(RUNNING), .BIST_END(BIST_END),
    .DATA_IN(DATA_IN), .CLEAR(CLEAR), .BUSY(busy[3]), .DONE(done[3]),
    .PASS(pass[3]), .FAIL(fail[3]), .SIGNATURE(sig[3]));

  logic [7:0] m_seed [NI] = '{8'hFF, 8'h01, 8'h80, 8'h00};
  logic [7:0] m_gold [NI] = '{GOLD89, 8'h04, 8'h00, 8'h00};
  int         m_exp  [NI] = '{89, 2, 89, 89};
  logic [7:0] m_sig  [NI];
  int         m_cnt  [NI];
  logic       m_pass [NI];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_sig[i] = m_seed[i];
      m_cnt[i] = 0;
    end
  endtask

  task automatic run_cycle(input logic [7:0] d);
    RUNNING = 1'b1;
    DATA_IN = d;
    tick();
    for (int i = 0; i < NI; i++) begin
      m_sig[i] = step(m_sig[i], d);
      if (m_cnt[i] < 255) m_cnt[i]++;
      chk($sformatf("sig_run[%0d]", i), sig[i], m_sig[i]);
    end
    chk("busy_run", busy[0], 1'b1);
  endtask

  task automatic end_run(input logic be);
    RUNNING  = 1'b0;
    BIST_END = be;
    DATA_IN  = 8'($urandom);
    tick();
    BIST_END = 1'b0;
    chk("busy_compare", busy[0], 1'b1);
    chk("done_compare", done[0], 1'b0);
    chk("sig_compare", sig[0], m_sig[0]);
    tick();
    for (int i = 0; i < NI; i++) begin
      m_pass[i] = be && (m_sig[i] == m_gold[i]) && (m_cnt[i] == m_exp[i]);
      chk($sformatf("done[%0d]", i), done[i], 1'b1);
      chk($sformatf("pass[%0d]", i), pass[i], m_pass[i]);
      chk($sformatf("fail[%0d]", i), fail[i], !m_pass[i]);
      chk($sformatf("busy_done[%0d]", i), busy[i], 1'b0);
    end
  endtask

  task automatic hold_check();
    for (int k = 0; k < 4; k++) begin
      RUNNING  = 1'($urandom);
      BIST_END = 1'($urandom);
      DATA_IN  = 8'($urandom);
      tick();
      chk("hold_done", done[0], 1'b1);
      chk("hold_pass", pass[0], m_pass[0]);
      chk("hold_fail", fail[0], !m_pass[0]);
      chk("hold_sig", sig[0], m_sig[0]);
    end
    RUNNING  = 1'b0;
    BIST_END = 1'b0;
  endtask

  task automatic do_clear();
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    model_reset();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("clr_sig[%0d]", i), sig[i], m_seed[i]);
      chk($sformatf("clr_done[%0d]", i), done[i], 1'b0);
    end
    chk("clr_pass", pass[0], 1'b0);
    chk("clr_fail", fail[0], 1'b0);
    chk("clr_busy", busy[0], 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s_sig[%0d]", tag, i), sig[i], m_seed[i]);
      chk($sformatf("%s_busy[%0d]", tag, i), busy[i], 1'b0);
      chk($sformatf("%s_done[%0d]", tag, i), done[i], 1'b0);
      chk($sformatf("%s_pass[%0d]", tag, i), pass[i], 1'b0);
      chk($sformatf("%s_fail[%0d]", tag, i), fail[i], 1'b0);
    end
  endtask

  initial begin
    int idx, bitn, len;
    logic [7:0] flip;
    RESET_N  = 1'b0;
    RUNNING  = 1'b0;
    BIST_END = 1'b0;
    CLEAR    = 1'b0;
    DATA_IN  = 8'h00;
    model_reset();
    repeat (2) tick();
    check_reset_state("por");
    RESET_N = 1'b1;
    tick();

    // BIST_END alone and CLEAR in IDLE must do nothing.
    BIST_END = 1'b1;
    CLEAR    = 1'b1;
    tick();
    BIST_END = 1'b0;
    CLEAR    = 1'b0;
    check_reset_state("idle_ign");

    // Two zero words: seed 01 walks 02, 04; seed 80 folds in the polynomial.
    run_cycle(8'h00);
    chk("small_sig1", sig[1], 8'h02);
    chk("s80_sig1", sig[2], 8'h1D);
    run_cycle(8'h00);
    chk("small_sig2", sig[1], 8'h04);
    end_run(1'b1);
    chk("small_pass", pass[1], 1'b1);
    do_clear();

    // Input XOR from a zero seed, then reset in the middle of the run.
    run_cycle(8'hAA);
    chk("s00_sig", sig[3], 8'hAA);
    for (int i = 0; i < 9; i++) run_cycle(8'($urandom));
    #2 RESET_N = 1'b0;
    RUNNING = 1'b0;
    model_reset();
    #1 check_reset_state("midrst");
    tick();
    RESET_N = 1'b1;
    tick();

    // Full-length run matching the built-in golden value.
    for (int i = 0; i < 89; i++) run_cycle(pat(i));
    end_run(1'b1);
    chk("gold_pass", pass[0], 1'b1);
    hold_check();
    do_clear();

    // One cycle short.
    for (int i = 0; i < 88; i++) run_cycle(pat(i));
    end_run(1'b1);
    chk("short_fail", fail[0], 1'b1);
    do_clear();

    // Single flipped response bit.
    idx  = $urandom_range(0, 88);
    bitn = $urandom_range(0, 7);
    flip = 8'(1 << bitn);
    for (int i = 0; i < 89; i++) run_cycle((i == idx) ? (pat(i) ^ flip) : pat(i));
    end_run(1'b1);
    chk("flip_fail", fail[0], 1'b1);
    do_clear();

    // Abort: RUNNING drops without BIST_END.
    for (int i = 0; i < 40; i++) run_cycle(8'($urandom));
    end_run(1'b0);
    chk("abort_fail", fail[0], 1'b1);
    chk("abort_pass", pass[0], 1'b0);
    hold_check();
    do_clear();

    // CLEAR pulsed mid-run is ignored; golden run still passes.
    for (int i = 0; i < 89; i++) begin
      CLEAR = (i == 30);
      run_cycle(pat(i));
    end
    CLEAR = 1'b0;
    end_run(1'b1);
    chk("clr_compact_pass", pass[0], 1'b1);
    do_clear();

    // Random runs, random length, data and end condition.
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 120);
      for (int i = 0; i < len; i++) run_cycle(8'($urandom));
      end_run(1'($urandom));
      do_clear();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
